// File: rtl/load_store_unit.sv
`default_nettype none
// =============================================================================
// load_store_unit : RV32I byte/half/word loads and stores onto a word-only memory
// Revision 1.0
// =============================================================================
module load_store_unit #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        stall,
   output logic        misaligned,
   output logic        err_sticky,
   output logic [31:0] err_addr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

   localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

   state_t           state_q, state_d;
   logic [31:0]      merge_q, merge_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             err_sticky_q, err_sticky_d;
   logic [31:0]      err_addr_q, err_addr_d;

   logic             is_b, is_h, is_w, f3_ok, out_of_range, blocked;
   logic [IDX_W-1:0] req_idx;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_data, st_merge;

   assign req_idx = addr[IDX_W+1:2];

   always_comb begin
      is_b = (funct3[1:0] == 2'b00);
      is_h = (funct3[1:0] == 2'b01);
      is_w = (funct3 == 3'b010);
      // funct3 x11 and 110 never legal; 100/101 only legal for loads
      f3_ok = (funct3[1:0] != 2'b11) && !(funct3[2] && (funct3[1] || req_we));
      out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
      blocked = !f3_ok || out_of_range || (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
   end

   always_comb begin
      case (addr[1:0])
         2'b00:   ld_byte = mem_rdata[7:0];
         2'b01:   ld_byte = mem_rdata[15:8];
         2'b10:   ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      if (is_b)
         ld_data = {{24{~funct3[2] & ld_byte[7]}}, ld_byte};
      else if (is_h)
         ld_data = {{16{~funct3[2] & ld_half[15]}}, ld_half};
      else
         ld_data = mem_rdata;

      st_merge = mem_rdata;
      if (is_b) begin
         case (addr[1:0])
            2'b00:   st_merge[7:0]   = wdata[7:0];
            2'b01:   st_merge[15:8]  = wdata[7:0];
            2'b10:   st_merge[23:16] = wdata[7:0];
            default: st_merge[31:24] = wdata[7:0];
         endcase
      end else if (addr[1]) begin
         st_merge[31:16] = wdata[15:0];
      end else begin
         st_merge[15:0] = wdata[15:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      merge_d      = merge_q;
      idx_d        = idx_q;
      err_sticky_d = err_sticky_q;
      err_addr_d   = err_addr_q;
      stall        = 1'b0;
      mem_we       = 1'b0;
      rdata_valid  = 1'b0;
      rdata        = 32'h0;
      misaligned   = 1'b0;
      mem_addr     = {{(32-IDX_W){1'b0}}, req_idx};
      mem_wdata    = wdata;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (blocked) begin
                  misaligned = 1'b1;
                  if (!err_sticky_q) begin
                     err_sticky_d = 1'b1;
                     err_addr_d   = addr;
                  end
               end else if (!req_we) begin
                  rdata_valid = 1'b1;
                  rdata       = ld_data;
               end else if (is_w) begin
                  mem_we = 1'b1;
               end else begin
                  stall   = 1'b1;
                  merge_d = st_merge;
                  idx_d   = req_idx;
                  state_d = RMW_WR;
               end
            end
         end
         RMW_WR: begin
            mem_addr  = {{(32-IDX_W){1'b0}}, idx_q};
            mem_we    = 1'b1;
            mem_wdata = merge_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A write pending in RMW_WR is abandoned when reset lands on it
      if (rst) begin
         mem_we      = 1'b0;
         stall       = 1'b0;
         rdata_valid = 1'b0;
         rdata       = 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         merge_q      <= 32'h0;
         idx_q        <= '0;
         err_sticky_q <= 1'b0;
         err_addr_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         merge_q      <= merge_d;
         idx_q        <= idx_d;
         err_sticky_q <= err_sticky_d;
         err_addr_q   <= err_addr_d;
      end
   end

   assign err_sticky = err_sticky_q;
   assign err_addr   = err_addr_q;

endmodule
`default_nettype wire
